seg7_scroll_buf: RTL

SEG7_SCROLL_BUF -- requirements
Module: seg7_scroll_buf

---
 rtl/seg7_scroll_buf.sv | 139 +++++++++++++
 1 files changed

// File: rtl/seg7_scroll_buf.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scroll_buf
// Description : Message buffer that scrolls its contents across a row of
//               display digits, moving one position every TICK_DIV clocks.
//               Optional macro SEG7_SCROLL_REVERSE_EN adds a Dir input that
//               lets the message scroll backwards.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scroll_buf #(
  parameter int NUM_DIGITS = 4,
  parameter int WIDTH      = 9,
  parameter int DEPTH      = 16,
  parameter int TICK_DIV   = 25000000
) (
  input  logic                          clock,
  input  logic                          Reset,
  input  logic                          Write,
  input  logic [$clog2(DEPTH)-1:0]      Address,
  input  logic [WIDTH-1:0]              valuein,
  input  logic [$clog2(DEPTH):0]        Length,
  input  logic                          Start,
  input  logic                          Stop,
`ifdef SEG7_SCROLL_REVERSE_EN
  input  logic                          Dir,
`endif
  output logic [NUM_DIGITS*WIDTH-1:0]   valueout,
  output logic                          Busy,
  output logic                          Wrap
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam int c_TW = $clog2(TICK_DIV);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  logic [WIDTH-1:0]            r_buf [DEPTH];
  logic [0:0]                  r_state;
  logic [c_LW-1:0]             r_len;
  logic [c_AW-1:0]             r_origin;
  logic [c_TW-1:0]             r_tick;
  logic                        r_wrap;
  logic [NUM_DIGITS*WIDTH-1:0] r_valueout;

  logic [c_LW-1:0]             w_len_sel;
  logic [c_LW-1:0]             w_fwd_inc;
  logic                        w_tick_end;
  logic [c_AW-1:0]             w_origin_nxt;
  logic                        w_wrap_nxt;
  logic [NUM_DIGITS*WIDTH-1:0] w_digits;

  // Message storage: writable in any state, cleared by reset
  always_ff @(posedge clock) begin
    if (Reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_buf[k] <= '0;
      end
    end else if (Write) begin
      r_buf[Address] <= valuein;
    end
  end

  // Lengths beyond the buffer are clamped to the full buffer
  assign w_len_sel  = (Length > c_LW'(DEPTH)) ? c_LW'(DEPTH) : Length;
  assign w_tick_end = (r_tick == c_TW'(TICK_DIV - 1));
  assign w_fwd_inc  = {1'b0, r_origin} + c_LW'(1);

  // Next origin for one scroll step, and whether that step wraps the message
  always_comb begin
    w_wrap_nxt   = (w_fwd_inc == r_len);
    w_origin_nxt = w_wrap_nxt ? '0 : w_fwd_inc[c_AW-1:0];
`ifdef SEG7_SCROLL_REVERSE_EN
    if (Dir) begin
      w_wrap_nxt   = (r_origin == '0);
      w_origin_nxt = w_wrap_nxt ? c_AW'(r_len - c_LW'(1)) : (r_origin - c_AW'(1));
    end
`endif
  end

  // Control FSM: Stop beats Start, Start (re)latches length and rewinds
  always_ff @(posedge clock) begin
    if (Reset) begin
      r_state  <= c_ST_IDLE;
      r_len    <= c_LW'(NUM_DIGITS);
      r_origin <= '0;
      r_tick   <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (Stop) begin
        r_state <= c_ST_IDLE;
      end else if (Start && (Length != '0)) begin
        r_state  <= c_ST_RUN;
        r_len    <= w_len_sel;
        r_origin <= '0;
        r_tick   <= '0;
      end else if (r_state == c_ST_RUN) begin
        if (w_tick_end) begin
          r_tick   <= '0;
          r_origin <= w_origin_nxt;
          r_wrap   <= w_wrap_nxt;
        end else begin
          r_tick <= r_tick + c_TW'(1);
        end
      end
    end
  end

  // Digit i shows entry (origin+i) mod len, built as a chain of wrapping
  // increments so short messages repeat across the digits without a divider
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [c_AW-1:0] w_idx;
    if (i == 0) begin : g_first
      assign w_idx = r_origin;
    end else begin : g_next
      logic [c_LW-1:0] w_inc;
      assign w_inc = {1'b0, g_digit[i-1].w_idx} + c_LW'(1);
      assign w_idx = (w_inc == r_len) ? '0 : w_inc[c_AW-1:0];
    end
    assign w_digits[i*WIDTH +: WIDTH] = r_buf[w_idx];
  end

  // Registered digit outputs, one cycle behind buffer/origin
  always_ff @(posedge clock) begin
    if (Reset) begin
      r_valueout <= '0;
    end else begin
      r_valueout <= w_digits;
    end
  end

  assign valueout = r_valueout;
  assign Busy     = (r_state == c_ST_RUN);
  assign Wrap     = r_wrap;

endmodule
`default_nettype wire
